// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
// lock_loss_cnt exists only when PLL_SEQ_STATUS_EN is defined.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;
`ifdef PLL_SEQ_STATUS_EN
  logic [7:0] lock_loss_cnt;

  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fault, state, lock_loss_cnt
  );
  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fault, state, lock_loss_cnt
  );
`else
  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fault, state
  );
  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fault, state
  );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor: pulses pll_rst, waits for a stable lock, releases sys_rst_n.
// Define PLL_SEQ_STATUS_EN to add the saturating lock_loss_cnt status output.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.slave  bus
);

  localparam int unsigned TIMER_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [7:0]         RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [15:0]        STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t               state_reg, state_next;
  logic [7:0]           rst_cnt_reg, rst_cnt_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [15:0]          stable_cnt_reg, stable_cnt_next;
  logic [3:0]           retry_cnt_reg, retry_cnt_next;
  logic [3:0]           retry_inc;
  logic                 pll_rst_reg, pll_rst_next;
  logic                 sys_rst_n_reg, sys_rst_n_next;
  logic                 lock_meta_reg, lock_s_reg;

  // A lock flag from a PLL held in reset means nothing, so the synchronizer is
  // flushed while pll_rst is high; every release needs a fresh 2-cycle observation.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else if (pll_rst_reg) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= bus.pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  assign retry_inc = (retry_cnt_reg == 4'hF) ? retry_cnt_reg : retry_cnt_reg + 4'd1;

  always_comb begin
    state_next      = state_reg;
    rst_cnt_next    = rst_cnt_reg;
    timer_next      = timer_reg;
    stable_cnt_next = stable_cnt_reg;
    retry_cnt_next  = retry_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next     = ST_PLL_RST;
        rst_cnt_next   = '0;
        retry_cnt_next = '0;
      end

      ST_PLL_RST: begin
        if (rst_cnt_reg >= RST_LAST) begin
          state_next = ST_WAIT_LOCK;
          timer_next = '0;
        end else begin
          rst_cnt_next = rst_cnt_reg + 8'd1;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s_reg) begin
          state_next      = ST_STABLE;
          stable_cnt_next = '0;
        end else if (timer_reg >= TIMER_LAST) begin
          retry_cnt_next = retry_inc;
          if (retry_inc < RETRY_LIMIT) begin
            state_next   = ST_PLL_RST;
            rst_cnt_next = '0;
          end else begin
            state_next = ST_FAULT;
          end
        end else if (timer_reg != TIMER_MAX) begin
          timer_next = timer_reg + TIMER_ONE;
        end
      end

      ST_STABLE: begin
        if (!lock_s_reg) begin
          state_next = ST_WAIT_LOCK;
          timer_next = '0;
        end else if (stable_cnt_reg >= STABLE_LAST) begin
          state_next     = ST_RUN;
          retry_cnt_next = '0;
        end else if (stable_cnt_reg != 16'hFFFF) begin
          stable_cnt_next = stable_cnt_reg + 16'd1;
        end
      end

      ST_RUN: begin
        if (!lock_s_reg) begin
          state_next   = ST_PLL_RST;
          rst_cnt_next = '0;
        end
      end

      ST_FAULT: begin
        state_next = ST_FAULT;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // restart overrides whatever the state logic decided this cycle
    if (bus.restart) begin
      state_next     = ST_PLL_RST;
      rst_cnt_next   = '0;
      retry_cnt_next = '0;
    end

    pll_rst_next   = (state_next == ST_IDLE) || (state_next == ST_PLL_RST) ||
                     (state_next == ST_FAULT);
    sys_rst_n_next = (state_next == ST_RUN);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rst_cnt_reg    <= '0;
      timer_reg      <= '0;
      stable_cnt_reg <= '0;
      retry_cnt_reg  <= '0;
      pll_rst_reg    <= 1'b1;
      sys_rst_n_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rst_cnt_reg    <= rst_cnt_next;
      timer_reg      <= timer_next;
      stable_cnt_reg <= stable_cnt_next;
      retry_cnt_reg  <= retry_cnt_next;
      pll_rst_reg    <= pll_rst_next;
      sys_rst_n_reg  <= sys_rst_n_next;
    end
  end

  assign bus.pll_rst   = pll_rst_reg;
  assign bus.sys_rst_n = sys_rst_n_reg;
  assign bus.ready     = (state_reg == ST_RUN);
  assign bus.fault     = (state_reg == ST_FAULT);
  assign bus.state     = state_reg;

`ifdef PLL_SEQ_STATUS_EN
  logic       loss_event;
  logic [7:0] lock_loss_cnt_reg;

  // Only a genuine RUN -> PLL_RST lock loss counts; a restart in RUN does not.
  assign loss_event = (state_reg == ST_RUN) && !lock_s_reg && !bus.restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt_reg <= '0;
    end else if (loss_event && (lock_loss_cnt_reg != 8'hFF)) begin
      lock_loss_cnt_reg <= lock_loss_cnt_reg + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = lock_loss_cnt_reg;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: refclk cycles pll_rst is held high per attempt (range 1..255).
REQ-002 Parameter LOCK_TIMEOUT, default 50000: max cycles waiting for synchronized lock per attempt (range 1..2^20-1).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release (range 1..65535).
REQ-004 Parameter MAX_RETRIES, default 3: lock attempts allowed before FAULT (range 1..15).
REQ-005 refclk  in  1  sole clock, 50 MHz board reference; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 pll_locked  in  1  PPU clock PLL lock flag, asynchronous to refclk.
REQ-008 restart  in  1  synchronous single-cycle request to re-run the full sequence.
REQ-009 pll_rst  out  1  active-high reset to the PPU clock PLL.
REQ-010 sys_rst_n  out  1  active-low reset to PPU logic; low unless state is RUN.
REQ-011 ready  out  1  high exactly when state is RUN.
REQ-012 fault  out  1  high exactly when state is FAULT.
REQ-013 state  out  3  current state encoding: IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.

Function
REQ-014 pll_locked shall pass a 2-flop synchronizer (lock_s); all decisions use lock_s only, adding 2 cycles latency.
REQ-015 IDLE: entered from reset; next cycle -> PLL_RST, retry counter cleared.
REQ-016 PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with timer cleared.
REQ-017 WAIT_LOCK: lock_s=1 -> STABLE with stable counter cleared; timer reaching LOCK_TIMEOUT with lock_s=0 -> retry counter +1, then PLL_RST if retries < MAX_RETRIES else FAULT.
REQ-018 STABLE: lock_s=0 at any cycle -> WAIT_LOCK, timer cleared, retry counter unchanged; STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-019 RUN: sys_rst_n=1 and ready=1 from the first RUN cycle; retry counter cleared on entry.
REQ-020 RUN: lock_s=0 -> PLL_RST next cycle; sys_rst_n=0 in that same next cycle (no glitch-free hold).
REQ-021 FAULT: pll_rst=1, sys_rst_n=0, held until restart or rst_n.
REQ-022 restart=1 in any state -> PLL_RST next cycle, retry counter cleared; restart wins over all simultaneous transitions.
REQ-023 Counters shall saturate, never wrap; timer width ceil(log2(LOCK_TIMEOUT+1)).
REQ-024 pll_rst and sys_rst_n shall be registered outputs (glitch-free).

Reset
REQ-025 rst_n low: immediately state=IDLE, pll_rst=1, sys_rst_n=0, ready=0, fault=0, all counters and synchronizer flops 0.
REQ-026 rst_n deassertion mid-sequence restarts from IDLE; no state retained.

Configuration
REQ-027 Macro PLL_SEQ_STATUS_EN defined: adds output lock_loss_cnt (8 bits), incremented on each RUN->PLL_RST loss-of-lock transition, saturating at 255, cleared only by rst_n.
REQ-028 Macro undefined: port lock_loss_cnt absent; all other behaviour identical.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-029 Release rst_n, pll_locked=1 throughout -> pll_rst high 4 cycles, ready=1 and sys_rst_n=1 by cycle 1+4+2+1+8 (±1), state=4.
REQ-030 pll_locked stays 0 -> two 4-cycle pll_rst pulses separated by 20-cycle waits, then state=5, fault=1, sys_rst_n=0 held.
REQ-031 In RUN, drop pll_locked for 1 cycle -> sys_rst_n=0 three cycles later, state=1, full re-sequence; lock_loss_cnt=1 with macro.
REQ-032 In STABLE, pulse pll_locked low at stable count 5 -> return to WAIT_LOCK, RUN reached only after 8 fresh locked cycles.
REQ-033 In FAULT, assert restart 1 cycle -> state=1 next cycle, fault=0, retry counter 0; assert rst_n low in WAIT_LOCK -> outputs at reset values immediately.
